instruction_fetch_queue: RTL
============================

// Module: instruction_fetch_queue
// PURPOSE
//  Fetch front-end upstream of the IF/ID pipeline register. Issues word fetches to a
//  multi-cycle instruction memory over a req/ack handshake, buffers returned words with
//  their PC+4 in a small queue and presents them to decode with valid/stall control.
//  Redirects (taken branch, jump, jr) flush the queue and restart fetch at a new PC.
// PARAMETERS
//  QUEUE_DEPTH  4             entries in the instruction queue (power of 2, >=2)
//  RESET_PC     32'h00400000  first fetch address after reset
// PORTS
//  clk              in   1   core clock, rising edge
//  reset            in   1   asynchronous, active-high
//  mem_req_o        out  1   fetch request to instruction memory
//  mem_addr_o       out  32  fetch byte address, word aligned
//  mem_ack_i        in   1   memory accepts request; mem_rdata_i valid same cycle
//  mem_rdata_i      in   32  fetched instruction word
//  redirect_i       in   1   one-cycle pulse: discard queue, fetch from redirect_pc_i
//  redirect_pc_i    in   32  redirect target; bits [1:0] forced to 0
//  stall_i          in   1   decode cannot accept; hold head entry
//  instr_valid_o    out  1   head entry valid
//  instr_o          out  32  head instruction
//  pc_plus_4_o      out  32  head PC+4, feeds IF/ID PC+4 register
// BEHAVIOUR
//  - Reset: mem_req_o=0, mem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, pc_plus_4_o=0,
//    queue empty, fetch_pc=RESET_PC, state FETCH. First request in first cycle after release.
//  - Handshake: one outstanding request max. Once mem_req_o=1, mem_req_o and mem_addr_o
//    hold stable until the cycle mem_ack_i=1; ack may arrive the same cycle as req.
//    Requests are never withdrawn.
//  - Issue rule: mem_req_o asserted only if count < QUEUE_DEPTH (count includes the
//    entry granted by a same-cycle ack); queue never overflows, no data is dropped.
//  - On ack (state FETCH): push {mem_rdata_i, mem_addr_o+4}; fetch_pc <= fetch_pc+4,
//    32-bit wrap (32'hFFFFFFFC -> 0).
//  - Pop: instr_valid_o & ~stall_i removes head. Push+pop same cycle: count unchanged.
//    Empty: instr_valid_o=0, instr_o/pc_plus_4_o hold last value. Ack->valid latency 1 cycle.
//  - FSM: FETCH  normal operation.
//         FLUSH  request outstanding at redirect; keep req/addr stable, discard data on ack,
//                then -> FETCH issuing at saved redirect PC.
//    FETCH->FLUSH: redirect_i while req high and no ack this cycle.
//    FETCH->FETCH: redirect_i with no req or with ack this cycle (data discarded).
//    FLUSH + new redirect_i: update saved redirect PC, stay FLUSH.
//  - Redirect priority over push/pop: queue count=0, instr_valid_o=0 next cycle.
//  - Reset mid-transaction: all state cleared asynchronously; memory side must abandon request.
// CONFIGURATION
//  IFQ_PERF_COUNTERS_EN defined: adds outputs stall_cycles_o[31:0] (cycles with
//  mem_req_o=0 due to full queue, or instr_valid_o=0 while ~stall_i) and
//  flush_count_o[15:0] (redirects), both saturating, reset 0.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared header mips_defs.vh: RESET_PC default, instruction/address widths,
//  fetch FSM state encodings (FETCH=1'b0, FLUSH=1'b1).
//  Sub-module ifq_fifo: sync FIFO (DATA_WIDTH=64, DEPTH=QUEUE_DEPTH), push/pop/flush,
//  count, head data combinational from storage; clk/reset as above.
// TESTING
//  1 Reset release, mem_ack_i tied 1 -> addresses 0x00400000,04,08,0C one per cycle;
//    instr_valid_o rises cycle after first ack; pc_plus_4_o=0x00400004.
//  2 stall_i=1 held, ack always 1 -> exactly 4 acks, then mem_req_o=0; release stall
//    -> 4 pops in order, fetching resumes at 0x00400010.
//  3 Ack 3-cycle latency, redirect_i to 0x00400103 while req pending -> FLUSH; ack data
//    discarded; next req addr 0x00400100; no stale instr_valid_o.
//  4 redirect_i same cycle as ack and pop -> queue empty next cycle, req to target next cycle.
//  5 redirect_pc_i=0xFFFFFFF8, ack 1 -> addresses FFFFFFF8, FFFFFFFC, 00000000.
//  6 reset asserted while req pending -> outputs to reset values immediately, no clk edge needed.

Source files
------------

// File: rtl/instruction_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
// Widths, the default reset PC, fetch FSM encodings and the queue entry layout
// used by the top level and its FIFO.
package instruction_fetch_queue_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0040_0000;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus_4;
  } ifq_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Bundle of the fetch queue's memory handshake, redirect and decode-side signals.
// Signals:
//   mem_req_o / mem_addr_o      fetch request and word-aligned byte address
//   mem_ack_i / mem_rdata_i     memory accept, read data valid in the same cycle
//   redirect_i / redirect_pc_i  one-cycle redirect pulse and its target
//   stall_i                     decode cannot accept the head entry
//   instr_valid_o / instr_o / pc_plus_4_o   head entry presented to decode
// Modports: master = the fetch queue, slave = memory + decode side.
interface instruction_fetch_queue_if;
  import instruction_fetch_queue_pkg::*;

  logic               mem_req_o;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic               mem_ack_i;
  logic [INSTR_W-1:0] mem_rdata_i;
  logic               redirect_i;
  logic [ADDR_W-1:0]  redirect_pc_i;
  logic               stall_i;
  logic               instr_valid_o;
  logic [INSTR_W-1:0] instr_o;
  logic [ADDR_W-1:0]  pc_plus_4_o;

  modport master (
    output mem_req_o, mem_addr_o, instr_valid_o, instr_o, pc_plus_4_o,
    input  mem_ack_i, mem_rdata_i, redirect_i, redirect_pc_i, stall_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, pc_plus_4_o,
    output mem_ack_i, mem_rdata_i, redirect_i, redirect_pc_i, stall_i
  );

endinterface

// File: rtl/instruction_fetch_queue_fifo.sv
// Synchronous FIFO holding fetched {instruction, PC+4} entries.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   push, pop    enqueue push_data / dequeue head (pop ignored when empty)
//   flush        empties the queue; takes priority over push and pop
//   push_data    entry written on push
//   head_data    oldest entry, read combinationally from storage
//   count        number of entries held (0..DEPTH)
module instruction_fetch_queue_fifo #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   push_data,
  output logic [DATA_WIDTH-1:0]   head_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop    = pop && (count != '0);
  // A full queue can still accept a push when the head leaves in the same cycle.
  assign do_push   = push && ((count != FULL_CNT) || do_pop);
  assign head_data = storage[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      storage[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch front-end ahead of the IF/ID register.
// Issues one word fetch at a time over a req/ack handshake, queues returned words
// with their PC+4 and presents the head to decode. A redirect flushes the queue and
// restarts fetching at the new (word-aligned) PC; a request already on the bus at
// redirect time is completed in FLUSH and its data thrown away.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   ifq          instruction_fetch_queue_if.master (memory, redirect, decode signals)
//   stall_cycles_o[31:0], flush_count_o[15:0]  saturating performance counters,
//                present only when IFQ_PERF_COUNTERS_EN is defined
// Parameters: QUEUE_DEPTH (power of 2, >= 2), RESET_PC (first fetch address).
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int unsigned       QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = DEFAULT_RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  instruction_fetch_queue_if.master  ifq
`ifdef IFQ_PERF_COUNTERS_EN
  ,
  output logic [31:0]                stall_cycles_o,
  output logic [15:0]                flush_count_o
`endif
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  fetch_state_t        state;
  logic                req_q;
  logic [ADDR_W-1:0]   addr_q;      // current request address == fetch PC
  logic [ADDR_W-1:0]   saved_pc;    // redirect target waiting out a FLUSH
  logic [ADDR_W-1:0]   target_pc;
  logic [INSTR_W-1:0]  hold_instr;
  logic [ADDR_W-1:0]   hold_pc4;
  logic                ack;
  logic                push;
  logic                pop;
  logic                valid;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_next;
  ifq_entry_t          push_entry;
  ifq_entry_t          head_entry;

  assign target_pc  = word_align(ifq.redirect_pc_i);
  assign ack        = req_q & ifq.mem_ack_i;
  assign valid      = (count != '0);
  assign pop        = valid & ~ifq.stall_i;
  // Data returned during FLUSH or alongside a redirect belongs to the old path.
  assign push       = ack & (state == FETCH) & ~ifq.redirect_i;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  assign push_entry.instr     = ifq.mem_rdata_i;
  assign push_entry.pc_plus_4 = addr_q + 32'd4;

  instruction_fetch_queue_fifo #(
    .DATA_WIDTH (ENTRY_W),
    .DEPTH      (QUEUE_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (ifq.redirect_i),
    .push_data  (push_entry),
    .head_data  (head_entry),
    .count      (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      saved_pc <= RESET_PC;
    end else begin
      case (state)
        FETCH: begin
          if (ifq.redirect_i) begin
            if (req_q && !ifq.mem_ack_i) begin
              // Request is on the bus and cannot be withdrawn: wait for its ack.
              state    <= FLUSH;
              saved_pc <= target_pc;
            end else begin
              addr_q <= target_pc;
              req_q  <= 1'b1;
            end
          end else if (ack) begin
            addr_q <= addr_q + 32'd4;
            req_q  <= (count_next < FULL_CNT);
          end else if (!req_q) begin
            req_q <= (count_next < FULL_CNT);
          end
        end
        FLUSH: begin
          if (ifq.redirect_i) saved_pc <= target_pc;
          // req_q stays high for the whole FLUSH, so mem_ack_i alone marks completion.
          if (ifq.mem_ack_i) begin
            state  <= FETCH;
            addr_q <= ifq.redirect_i ? target_pc : saved_pc;
            req_q  <= 1'b1;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Remember the last head so decode sees stable values while the queue is empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_instr <= '0;
      hold_pc4   <= '0;
    end else if (valid) begin
      hold_instr <= head_entry.instr;
      hold_pc4   <= head_entry.pc_plus_4;
    end
  end

  assign ifq.mem_req_o     = req_q;
  assign ifq.mem_addr_o    = addr_q;
  assign ifq.instr_valid_o = valid;
  assign ifq.instr_o       = valid ? head_entry.instr     : hold_instr;
  assign ifq.pc_plus_4_o   = valid ? head_entry.pc_plus_4 : hold_pc4;

`ifdef IFQ_PERF_COUNTERS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  logic starved;
  assign starved = (~req_q & (count == FULL_CNT)) | (~valid & ~ifq.stall_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      if (starved)        stall_cycles_o <= sat_inc32(stall_cycles_o);
      if (ifq.redirect_i) flush_count_o  <= sat_inc16(flush_count_o);
    end
  end
`endif

endmodule
